// File: rtl/mealy_stream_ctrl.sv
// Sequencer that shifts a parallel pattern MSB-first into a serial Mealy machine,
// holding the machine in reset between jobs and tallying its detections.
module mealy_stream_ctrl #(
    parameter int LEN = 16,
    parameter int LW  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [LEN-1:0] pattern,
    input  logic [LW-1:0]  len,
    output logic           busy,
    output logic           done,
    output logic           fsm_rst_n,
    output logic           fsm_in,
    input  logic           fsm_out,
    output logic [LW-1:0]  match_cnt,
    output logic [LW-1:0]  first_idx,
    output logic           first_vld,
    output logic [1:0]     state_dbg
);

    // Handshake: start is a one-cycle request honoured only in IDLE with 1<=len<=LEN;
    // done is a one-cycle completion pulse; there is no backpressure and no queuing.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [LEN-1:0] r_shift;
    logic [LW-1:0]  r_len;
    logic [LW-1:0]  r_cnt;
    logic           r_fsm_in;
    logic [LW-1:0]  r_match_cnt;
    logic [LW-1:0]  r_first_idx;
    logic           r_first_vld;

    logic           w_len_ok;
    logic [LW-1:0]  w_shamt;
    logic [LEN-1:0] w_shift_nxt;
    logic           w_last;

    assign w_len_ok    = (len != '0) && (len <= LW'(LEN));
    assign w_shamt     = LW'(LEN) - len;
    assign w_shift_nxt = r_shift << 1;
    assign w_last      = (r_cnt == (r_len - LW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_fsm_in    <= 1'b0;
            r_match_cnt <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_len_ok) begin
                        // Left-justify so pattern[len-1] sits at the MSB and goes out first.
                        r_shift     <= pattern << w_shamt;
                        r_len       <= len;
                        r_match_cnt <= '0;
                        r_first_idx <= '0;
                        r_first_vld <= 1'b0;
                        r_state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state  <= S_RUN;
                        r_cnt    <= '0;
                        r_fsm_in <= r_shift[LEN-1];
                    end
                end
                S_RUN: begin
                    // The bit cycle ending now is sampled even when abort is raised in it.
                    if (fsm_out) begin
                        if (r_match_cnt != '1) begin
                            r_match_cnt <= r_match_cnt + LW'(1);
                        end
                        if (!r_first_vld) begin
                            r_first_idx <= r_cnt;
                            r_first_vld <= 1'b1;
                        end
                    end
                    r_shift <= w_shift_nxt;
                    r_cnt   <= r_cnt + LW'(1);
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_fsm_in <= 1'b0;
                    end else if (w_last) begin
                        r_state  <= S_DONE;
                        r_fsm_in <= 1'b0;
                    end else begin
                        r_fsm_in <= w_shift_nxt[LEN-1];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign fsm_rst_n = (r_state == S_ARM) || (r_state == S_RUN);
    assign fsm_in    = r_fsm_in;
    assign match_cnt = r_match_cnt;
    assign first_idx = r_first_idx;
    assign first_vld = r_first_vld;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// Directed bench for mealy_stream_ctrl: jobs push expected results into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_mealy_stream_ctrl;

    localparam int LEN = 16;
    localparam int LW  = 5;
    localparam int W   = 4 * LW + LEN + 1;

    localparam int O_NR   = 0;
    localparam int O_NB   = LW;
    localparam int O_BITS = 2 * LW;
    localparam int O_VLD  = 2 * LW + LEN;
    localparam int O_IDX  = 2 * LW + LEN + 1;
    localparam int O_CNT  = 3 * LW + LEN + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [LEN-1:0] pattern;
    logic [LW-1:0]  len;
    logic           busy;
    logic           done;
    logic           fsm_rst_n;
    logic           fsm_in;
    logic           fsm_out;
    logic [LW-1:0]  match_cnt;
    logic [LW-1:0]  first_idx;
    logic           first_vld;
    logic [1:0]     state_dbg;
    logic           loopback;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    mealy_stream_ctrl #(.LEN(LEN), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .fsm_rst_n (fsm_rst_n),
        .fsm_in    (fsm_in),
        .fsm_out   (fsm_out),
        .match_cnt (match_cnt),
        .first_idx (first_idx),
        .first_vld (first_vld),
        .state_dbg (state_dbg)
    );

    assign fsm_out = loopback ? fsm_in : 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input int cnt, input int idx, input int vld,
                                          input logic [LEN-1:0] bits, input int nb, input int nr);
        return {LW'(cnt), LW'(idx), 1'(vld), bits, LW'(nb), LW'(nr)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one start and waits for done; lat counts edges from start acceptance to DONE.
    task automatic start_job(input logic [LEN-1:0] pat, input logic [LW-1:0] l,
                             input logic lp, output int lat);
        pattern  = pat;
        len      = l;
        loopback = lp;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (lat < 60) begin
            @(negedge clk);
            if (done) break;
            tick();
            lat++;
        end
        if (lat >= 60) begin
            n_checks++;
            n_errors++;
            $display("FAIL job_timeout: got no done within %0d cycles", lat);
        end
        tick();
    endtask

    // Monitor: collects serial bits and cycle counts per job, compares on done.
    logic [LEN-1:0] mon_bits;
    int             mon_busy;
    int             mon_rstn;
    logic [W-1:0]   mon_e;

    always @(negedge clk) begin
        if (rst || state_dbg == ST_IDLE) begin
            mon_bits = '0;
            mon_busy = 0;
            mon_rstn = 0;
        end else begin
            if (busy) begin
                mon_bits = {mon_bits[LEN-2:0], fsm_in};
                mon_busy++;
            end
            if (fsm_rst_n) mon_rstn++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done with match_cnt=%0d, required no done", match_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_match_cnt", 32'(match_cnt), 32'(mon_e[O_CNT +: LW]));
                    check("sb_first_idx", 32'(first_idx), 32'(mon_e[O_IDX +: LW]));
                    check("sb_first_vld", 32'(first_vld), 32'(mon_e[O_VLD]));
                    check("sb_bits_sent", 32'(mon_bits), 32'(mon_e[O_BITS +: LEN]));
                    check("sb_busy_cycles", 32'(mon_busy), 32'(mon_e[O_NB +: LW]));
                    check("sb_rstn_cycles", 32'(mon_rstn), 32'(mon_e[O_NR +: LW]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        int n;
        logic [LW-1:0] bad_len[2];

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        pattern  = '0;
        len      = '0;
        loopback = 1'b1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fsm_rst_n", 32'(fsm_rst_n), 0);
        check("rst_fsm_in", 32'(fsm_in), 0);
        check("rst_match_cnt", 32'(match_cnt), 0);
        check("rst_first_idx", 32'(first_idx), 0);
        check("rst_first_vld", 32'(first_vld), 0);
        tick();
        rst = 1'b0;
        tick();

        // Loopback A5F0 full length, then results must hold with a stray abort in IDLE
        exp_q.push_back(pack(8, 0, 1, 16'hA5F0, 16, 17));
        start_job(16'hA5F0, 5'd16, 1'b1, lat);
        check("j1_latency", 32'(lat), 18);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        @(negedge clk);
        check("hold_match_cnt", 32'(match_cnt), 8);
        check("hold_first_vld", 32'(first_vld), 1);
        check("hold_state", 32'(state_dbg), 32'(ST_IDLE));
        tick();

        // Short length
        exp_q.push_back(pack(2, 0, 1, 16'h0003, 2, 3));
        start_job(16'h0003, 5'd2, 1'b1, lat);
        check("short_latency", 32'(lat), 4);

        // No detection
        exp_q.push_back(pack(0, 0, 0, 16'hFFFF, 16, 17));
        start_job(16'hFFFF, 5'd16, 1'b0, lat);
        check("nodet_latency", 32'(lat), 18);

        // Abort on RUN cycle k=5
        pattern  = 16'hFFFF;
        len      = 5'd16;
        loopback = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("abort_pre_state", 32'(state_dbg), 32'(ST_RUN));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        check("abort_busy", 32'(busy), 0);
        check("abort_fsm_rst_n", 32'(fsm_rst_n), 0);
        check("abort_match_cnt", 32'(match_cnt), 6);
        check("abort_first_vld", 32'(first_vld), 1);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 0);
        tick();

        // New start accepted after abort; first detection at k=1
        exp_q.push_back(pack(2, 1, 1, 16'h0012, 6, 7));
        start_job(16'h0012, 5'd6, 1'b1, lat);
        check("post_abort_latency", 32'(lat), 8);

        // Illegal lengths are ignored
        bad_len[0] = 5'd0;
        bad_len[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            pattern = 16'hFFFF;
            len     = bad_len[i];
            start   = 1'b1;
            tick();
            start = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("badlen_busy", 32'(busy), 0);
                check("badlen_state", 32'(state_dbg), 32'(ST_IDLE));
            end
            tick();
        end

        // Second start during RUN is ignored
        exp_q.push_back(pack(2, 7, 1, 16'h0180, 16, 17));
        pattern  = 16'h0180;
        len      = 5'd16;
        loopback = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        pattern = 16'hFFFF;
        len     = 5'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (done) break;
            tick();
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            n_errors++;
            $display("FAIL overlap_timeout: got no done within %0d cycles", n);
        end
        tick();

        // Reset mid-job on RUN cycle 3
        pattern  = 16'hFFFF;
        len      = 5'd16;
        loopback = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("midrst_busy", 32'(busy), 0);
        check("midrst_fsm_rst_n", 32'(fsm_rst_n), 0);
        check("midrst_fsm_in", 32'(fsm_in), 0);
        check("midrst_match_cnt", 32'(match_cnt), 0);
        check("midrst_first_idx", 32'(first_idx), 0);
        check("midrst_first_vld", 32'(first_vld), 0);
        check("midrst_done", 32'(done), 0);
        tick();
        repeat (3) tick();

        check("sb_queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mealy_stream_ctrl.md
Name: mealy_stream_ctrl

Overview:
- Sequencer that drives a serial-input Mealy machine from a parallel pattern word and collects its results.
- Per job:
  - holds the machine in reset while idle;
  - releases reset, shifts the pattern out MSB-first at one bit per cycle;
  - samples the machine's Mealy output each bit cycle;
  - counts detections and records the index of the first detection.
- Sits between a host/test harness and the mealy_machine instance; replaces hand-written per-cycle stimulus.

Parameters:
- LEN, 16, maximum pattern length in bits.
- LW, 5, width of length/count/index fields; must satisfy 2^LW > LEN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle job request; sampled only in IDLE
- abort  input  1  cancel running job
- pattern  input  LEN  bit stream; pattern[len-1] is sent first
- len  input  LW  number of bits to send, 1..LEN
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when a job completes normally
- fsm_rst_n  output  1  active-low reset to the Mealy machine
- fsm_in  output  1  serial bit to the Mealy machine
- fsm_out  input  1  Mealy output of the machine (combinational on fsm_in and state)
- match_cnt  output  LW  detections counted in the last/current job
- first_idx  output  LW  bit index (0 = first bit sent) of first detection
- first_vld  output  1  first_idx is valid

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high. rst has priority over all other inputs.
- Reset values:
  - state IDLE
  - busy 0, done 0
  - fsm_rst_n 0, fsm_in 0
  - match_cnt 0, first_idx 0, first_vld 0
  - internal shift register 0, bit counter 0
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - fsm_rst_n=0, fsm_in=0.
  - On start=1 with 1<=len<=LEN: latch pattern into the shift register, latch len, clear match_cnt/first_idx/first_vld, go to ARM.
  - start with len=0 or len>LEN is ignored: stays IDLE, no done.
- ARM (exactly 1 cycle):
  - fsm_rst_n=1 so the machine leaves reset in its initial state.
  - fsm_in=0; fsm_out is not sampled.
  - Next state RUN with bit counter=0.
- RUN:
  - busy=1, fsm_rst_n=1.
  - fsm_in is driven from a register: equals the latched pattern bit len-1-k during bit cycle k.
  - Each cycle fsm_out is sampled at the rising edge that ends the bit cycle, then the shift register advances. fsm_in changes only at clock edges.
  - On sampled fsm_out=1:
    - match_cnt increments; saturates at 2^LW-1.
    - If first_vld=0: first_idx<=k, first_vld<=1.
  - After the cycle with k=len-1, go to DONE. A job spans exactly len RUN cycles.
- DONE (1 cycle):
  - done=1, busy=0.
  - fsm_rst_n=0, fsm_in=0.
  - Next state IDLE.
  - Results hold until the next accepted start.
- abort=1 in ARM or RUN:
  - Next state IDLE, fsm_rst_n=0, no done pulse.
  - match_cnt/first_* keep their partial values.
- abort in IDLE or DONE has no effect.
- start while not IDLE is ignored; no queuing.
- start and abort together in IDLE: start accepted.
- rst mid-job: all outputs return to reset values on the next edge.

Test Plan:
- Loopback: bench ties fsm_out=fsm_in; start with pattern=16'hA5F0, len=16.
  - Expect busy for 16 cycles, fsm_in sequence 1010_0101_1111_0000.
  - Expect match_cnt=8, first_idx=0, first_vld=1, then a single done pulse.
- Short length: loopback, pattern=16'h0003, len=2.
  - Expect bits sent 1,1; match_cnt=2, first_idx=0.
  - Expect done 4 cycles after start (ARM, RUN, RUN, DONE).
- No detection: fsm_out tied 0; pattern=16'hFFFF, len=16.
  - Expect match_cnt=0, first_vld=0, done pulse.
  - Expect fsm_rst_n high exactly 17 cycles (ARM + 16 RUN).
- Abort: loopback, pattern=16'hFFFF, len=16; abort asserted on RUN cycle 5 (k=5).
  - Expect IDLE next cycle, no done, match_cnt=6, fsm_rst_n=0.
  - A new start is then accepted.
- Illegal/overlap:
  - start with len=0 -> stays IDLE, no busy.
  - Second start during RUN -> ignored; the first job completes with its original results.
- Reset mid-job: rst on RUN cycle 3 -> next edge busy=0, fsm_rst_n=0, match_cnt=0, first_vld=0, state IDLE.
